// File: rtl/multi_sample_ctrl.sv
// ============================================================================
// Module   : multi_sample_ctrl
// Brief    : Divider-paced, mask-sequenced ADC trigger controller with burst
//            mode. Optional external burst trigger: SAMPLE_CTRL_EXT_TRIG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_sample_ctrl #(
    parameter int CH_NUM  = 4,
    parameter int DIV_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic                                      Clk,
    input  logic                                      Rst,
    input  logic                                      m_wr,
    input  logic [7:0]                                m_addr,
    input  logic [15:0]                               m_wrdata,
`ifdef SAMPLE_CTRL_EXT_TRIG_EN
    input  logic                                      Ext_Trig,
`endif
    output logic                                      ADC_En,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] ADC_Ch,
    output logic                                      Busy,
    output logic                                      Burst_Done
);

    localparam int               CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(49999);
    localparam logic [7:0]       A_DIV_LO = 8'd1;
    localparam logic [7:0]       A_DIV_HI = 8'd2;
    localparam logic [7:0]       A_CTRL   = 8'd3;
    localparam logic [7:0]       A_MASK   = 8'd4;
    localparam logic [7:0]       A_BLEN   = 8'd5;
    localparam logic [7:0]       A_START  = 8'd6;

    logic [DIV_W-1:0]   div_q, div_d, cnt_q, cnt_d;
    logic               run_q, run_d, mode_q, mode_d;
    logic [CH_NUM-1:0]  mask_q, mask_d;
    logic [BURST_W-1:0] blen_q, blen_d, rem_q, rem_d;
    logic [CH_W-1:0]    ptr_q, ptr_d, ch_q, ch_d;
    logic               en_q, en_d, busy_q, busy_d, done_q, done_d;

    logic w_active, w_trig, w_start_req, w_start_ok, w_abort, w_last;

    function automatic logic [CH_W-1:0] lowest_bit(input logic [CH_NUM-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Smallest set bit strictly above p, wrapping to the lowest set bit.
    function automatic logic [CH_W-1:0] next_bit(input logic [CH_NUM-1:0] m,
                                                 input logic [CH_W-1:0]   p);
        logic [CH_W-1:0] r;
        r = lowest_bit(m);
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i] && (CH_W'(i) > p)) r = CH_W'(i);
        end
        return r;
    endfunction

`ifdef SAMPLE_CTRL_EXT_TRIG_EN
    logic ext_q;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) ext_q <= 1'b0;
        else     ext_q <= Ext_Trig;
    end
    assign w_start_req = (m_wr && (m_addr == A_START)) || (Ext_Trig && !ext_q);
`else
    assign w_start_req = m_wr && (m_addr == A_START);
`endif

    always_comb begin
        w_active   = run_q && (!mode_q || busy_q);
        w_trig     = w_active && (cnt_q >= div_q) && (mask_q != '0);
        w_start_ok = w_start_req && run_q && mode_q && !busy_q;
        w_abort    = busy_q && m_wr && (m_addr == A_CTRL) && !(m_wrdata[0] && m_wrdata[1]);
        w_last     = w_trig && busy_q && (rem_q == BURST_W'(1));

        div_d  = div_q;
        run_d  = run_q;
        mode_d = mode_q;
        mask_d = mask_q;
        blen_d = blen_q;
        if (m_wr) begin
            if (m_addr == A_DIV_LO) div_d[15:0] = m_wrdata;
            if (m_addr == A_DIV_HI) begin
                for (int i = 16; i < DIV_W; i++) div_d[i] = m_wrdata[i-16];
            end
            if (m_addr == A_CTRL) begin
                run_d  = m_wrdata[0];
                mode_d = m_wrdata[1];
            end
            if (m_addr == A_MASK) mask_d = m_wrdata[CH_NUM-1:0];
            if (m_addr == A_BLEN) blen_d = m_wrdata[BURST_W-1:0];
        end

        if (!w_active || (cnt_q >= div_q) || w_start_ok) cnt_d = '0;
        else                                               cnt_d = cnt_q + DIV_W'(1);

        ptr_d = ptr_q;
        if (w_trig) ptr_d = next_bit(mask_q, ptr_q);
        if (m_wr && (m_addr == A_MASK)) ptr_d = lowest_bit(m_wrdata[CH_NUM-1:0]);
        if (w_start_ok) ptr_d = lowest_bit(mask_q);

        en_d = w_trig;
        ch_d = w_trig ? ptr_q : ch_q;

        busy_d = busy_q;
        if (w_start_ok && (blen_q != '0)) busy_d = 1'b1;
        if (w_last || w_abort)            busy_d = 1'b0;

        rem_d = rem_q;
        if (w_start_ok)          rem_d = blen_q;
        else if (w_trig && busy_q) rem_d = rem_q - BURST_W'(1);

        // Zero-length burst completes immediately without raising Busy.
        done_d = w_last || (w_start_ok && (blen_q == '0));
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            mode_q <= 1'b0;
            mask_q <= CH_NUM'(1);
            blen_q <= BURST_W'(1);
            rem_q  <= '0;
            ptr_q  <= '0;
            ch_q   <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            mode_q <= mode_d;
            mask_q <= mask_d;
            blen_q <= blen_d;
            rem_q  <= rem_d;
            ptr_q  <= ptr_d;
            ch_q   <= ch_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign ADC_En     = en_q;
    assign ADC_Ch     = ch_q;
    assign Busy       = busy_q;
    assign Burst_Done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_sample_ctrl.sv
// ============================================================================
// Module   : tb_multi_sample_ctrl
// Brief    : Directed self-checking bench for multi_sample_ctrl (CH_NUM=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_sample_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = 8'd0;
    logic [15:0] m_wrdata = 16'd0;
    logic        ADC_En;
    logic [1:0]  ADC_Ch;
    logic        Busy;
    logic        Burst_Done;

    int checks = 0;
    int failures = 0;

    multi_sample_ctrl #(.CH_NUM(4), .DIV_W(32), .BURST_W(16)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .m_wr       (m_wr),
        .m_addr     (m_addr),
        .m_wrdata   (m_wrdata),
        .ADC_En     (ADC_En),
        .ADC_Ch     (ADC_Ch),
        .Busy       (Busy),
        .Burst_Done (Burst_Done)
    );

    always #5 Clk = ~Clk;

    // Called at a falling edge; returns at the falling edge after the write edge.
    task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
        m_wr = 1'b1; m_addr = a; m_wrdata = d;
        @(negedge Clk);
        m_wr = 1'b0; m_addr = 8'd0; m_wrdata = 16'd0;
    endtask

    task automatic do_reset;
        Rst = 1'b1; m_wr = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Falling edges until ADC_En is seen; -1 if the limit expires.
    task automatic wait_en(input int limit, output int n);
        n = 0;
        while (1) begin
            @(negedge Clk);
            n++;
            if (ADC_En) return;
            if (n >= limit) begin n = -1; return; end
        end
    endtask

    task automatic test_reset;
        int n;
        Rst = 1'b1; m_wr = 1'b0;
        @(negedge Clk);
        checks++; if (ADC_En !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", ADC_En); end
        checks++; if (ADC_Ch !== 2'd0) begin failures++; $display("FAIL rst_ch got=%0d exp=0", ADC_Ch); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", Busy); end
        checks++; if (Burst_Done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", Burst_Done); end
        @(negedge Clk);
        Rst = 1'b0;
        wait_en(60000, n);
        checks++; if (n !== 50000) begin failures++; $display("FAIL default_period got=%0d exp=50000", n); end
        checks++; if (ADC_Ch !== 2'd0) begin failures++; $display("FAIL default_ch got=%0d exp=0", ADC_Ch); end
        @(negedge Clk);
        checks++; if (ADC_En !== 1'b0) begin failures++; $display("FAIL default_single_pulse got=%b exp=0", ADC_En); end
    endtask

    task automatic test_round_robin;
        int n;
        logic [1:0] exp_ch [6];
        exp_ch = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        do_reset();
        write_reg(8'd1, 16'd9);
        write_reg(8'd4, 16'b1011);
        for (int p = 0; p < 6; p++) begin
            wait_en(40, n);
            checks++;
            if (n !== ((p == 0) ? 8 : 10)) begin
                failures++; $display("FAIL rr_interval[%0d] got=%0d exp=%0d", p, n, (p == 0) ? 8 : 10);
            end
            checks++;
            if (ADC_Ch !== exp_ch[p]) begin
                failures++; $display("FAIL rr_ch[%0d] got=%0d exp=%0d", p, ADC_Ch, exp_ch[p]);
            end
        end
    endtask

    task automatic test_burst;
        int n, exp_n;
        do_reset();
        write_reg(8'd3, 16'd3);
        write_reg(8'd1, 16'd3);
        write_reg(8'd5, 16'd5);
        write_reg(8'd6, 16'd0);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL burst_busy_start got=%b exp=1", Busy); end
        for (int p = 1; p <= 5; p++) begin
            exp_n = 4;
            if (p == 3) begin
                write_reg(8'd6, 16'd0);
                exp_n = 3;
            end
            wait_en(20, n);
            checks++; if (n !== exp_n) begin failures++; $display("FAIL burst_interval[%0d] got=%0d exp=%0d", p, n, exp_n); end
            checks++; if (Burst_Done !== (p == 5)) begin failures++; $display("FAIL burst_done[%0d] got=%b exp=%b", p, Burst_Done, (p == 5)); end
            checks++; if (Busy !== (p != 5)) begin failures++; $display("FAIL burst_busy[%0d] got=%b exp=%b", p, Busy, (p != 5)); end
        end
        wait_en(20, n);
        checks++; if (n !== -1) begin failures++; $display("FAIL burst_extra_pulse got=%0d exp=-1", n); end
    endtask

    task automatic test_abort;
        int n, en_seen, done_seen;
        do_reset();
        write_reg(8'd3, 16'd3);
        write_reg(8'd1, 16'd3);
        write_reg(8'd5, 16'd100);
        write_reg(8'd6, 16'd0);
        for (int p = 0; p < 3; p++) begin
            wait_en(20, n);
            checks++; if (n !== 4) begin failures++; $display("FAIL abort_interval[%0d] got=%0d exp=4", p, n); end
        end
        write_reg(8'd3, 16'd0);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", Busy); end
        en_seen = 0; done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (ADC_En) en_seen++;
            if (Burst_Done) done_seen++;
            @(negedge Clk);
        end
        checks++; if (en_seen !== 0) begin failures++; $display("FAIL abort_en got=%0d exp=0", en_seen); end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_seen); end
        write_reg(8'd3, 16'd3);
        write_reg(8'd5, 16'd0);
        write_reg(8'd6, 16'd0);
        checks++; if (Burst_Done !== 1'b1) begin failures++; $display("FAIL blen0_done got=%b exp=1", Burst_Done); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL blen0_busy got=%b exp=0", Busy); end
        @(negedge Clk);
        checks++; if (Burst_Done !== 1'b0) begin failures++; $display("FAIL blen0_done_width got=%b exp=0", Burst_Done); end
        wait_en(20, n);
        checks++; if (n !== -1) begin failures++; $display("FAIL blen0_en got=%0d exp=-1", n); end
    endtask

    task automatic test_div_lower;
        int n;
        do_reset();
        write_reg(8'd1, 16'd49);
        wait_en(100, n);
        checks++; if (n !== 49) begin failures++; $display("FAIL div49_first got=%0d exp=49", n); end
        repeat (40) @(negedge Clk);
        write_reg(8'd1, 16'd20);
        checks++; if (ADC_En !== 1'b0) begin failures++; $display("FAIL divlow_early got=%b exp=0", ADC_En); end
        wait_en(40, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL divlow_wrap got=%0d exp=1", n); end
        for (int p = 0; p < 2; p++) begin
            wait_en(40, n);
            checks++; if (n !== 21) begin failures++; $display("FAIL divlow_period[%0d] got=%0d exp=21", p, n); end
        end
    endtask

    task automatic test_reset_mid_burst;
        int n;
        do_reset();
        write_reg(8'd3, 16'd3);
        write_reg(8'd1, 16'd3);
        write_reg(8'd5, 16'd5);
        write_reg(8'd4, 16'b0100);
        write_reg(8'd6, 16'd0);
        wait_en(20, n);
        checks++; if (ADC_Ch !== 2'd2) begin failures++; $display("FAIL midrst_pre_ch got=%0d exp=2", ADC_Ch); end
        #2 Rst = 1'b1;
        #1;
        checks++; if (ADC_En !== 1'b0) begin failures++; $display("FAIL midrst_en got=%b exp=0", ADC_En); end
        checks++; if (ADC_Ch !== 2'd0) begin failures++; $display("FAIL midrst_ch got=%0d exp=0", ADC_Ch); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
        @(negedge Clk);
        Rst = 1'b0;
        // MODE defaults to continuous, so START must be ignored.
        write_reg(8'd6, 16'd0);
        checks++; if (Busy !== 1'b0 || Burst_Done !== 1'b0) begin
            failures++; $display("FAIL midrst_mode_default got=%b%b exp=00", Busy, Burst_Done);
        end
        write_reg(8'd3, 16'd3);
        write_reg(8'd1, 16'd3);
        write_reg(8'd6, 16'd0);
        wait_en(20, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL midrst_blen_default_int got=%0d exp=4", n); end
        checks++; if (Burst_Done !== 1'b1 || Busy !== 1'b0) begin
            failures++; $display("FAIL midrst_blen_default got=%b%b exp=10", Burst_Done, Busy);
        end
        checks++; if (ADC_Ch !== 2'd0) begin failures++; $display("FAIL midrst_mask_default got=%0d exp=0", ADC_Ch); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_abort();
        test_div_lower();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
